// File: rtl/cipher_pkg.sv
// cipher_pkg: widths shared by the block assembler and the XOR cipher stage
package cipher_pkg;
  localparam int WORD_W = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int BLK_W = WORDS_PER_BLK * WORD_W;
  localparam int CNT_W = $clog2(WORDS_PER_BLK);
endpackage

// File: rtl/cipher_block_assembler.sv
// cipher_block_assembler: packs 32-bit words into 128-bit keys or data blocks for the cipher stage
module cipher_block_assembler
  import cipher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_is_key,
  input  logic              key_clr,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [BLK_W-1:0]  blk_data,
  output logic [BLK_W-1:0]  blk_key,
  output logic              key_valid,
  output logic              err_mix,
  output logic              err_nokey
);
  logic [BLK_W-1:0] sh, key_reg, asm_v;
  logic [CNT_W-1:0] cnt;
  logic grp_key, acc, restart, mix, done;
  assign in_ready = rst && !blk_valid;
  assign acc = in_valid && in_ready && !key_clr;
  assign restart = (cnt == '0) || (in_is_key != grp_key);
  assign mix = acc && (cnt != '0) && (in_is_key != grp_key);
  assign done = acc && !restart && (cnt == CNT_W'(WORDS_PER_BLK - 1));
  // stale bits from an abandoned group are shifted out before any completion
  assign asm_v = {sh[BLK_W-WORD_W-1:0], in_word};
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh <= '0;
      key_reg <= '0;
      cnt <= '0;
      grp_key <= 1'b0;
      key_valid <= 1'b0;
      blk_valid <= 1'b0;
      blk_data <= '0;
      blk_key <= '0;
      err_mix <= 1'b0;
      err_nokey <= 1'b0;
    end else begin
      err_mix <= mix;
      err_nokey <= done && !grp_key && !key_valid;
      if (blk_valid && blk_ready) blk_valid <= 1'b0;
      if (key_clr) begin
        key_reg <= '0;
        key_valid <= 1'b0;
        cnt <= '0;
      end else if (acc) begin
        sh <= asm_v;
        cnt <= restart ? CNT_W'(1) : cnt + CNT_W'(1);
        grp_key <= restart ? in_is_key : grp_key;
        if (done && grp_key) begin
          key_reg <= asm_v;
          key_valid <= 1'b1;
        end
        if (done && !grp_key && key_valid) begin
          blk_data <= asm_v;
          blk_key <= key_reg;
          blk_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/cipher_block_assembler.md
# cipher_block_assembler

Upstream feeder for the 128-bit XOR cipher stage. It accepts a stream of 32-bit words over a valid/ready handshake. Each 4-word group is assembled into either a 128-bit key, which is held in a key register, or a 128-bit data block. Each completed data block is presented to the cipher stage together with a snapshot of the current key, through a single-entry output register with valid/ready.

## Interface
- WORD_W, 32, input word width; fixed at 32 in this revision.
- BLK_W, 128, block/key width; BLK_W = 4*WORD_W.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  word offered.
- in_ready  output  1  word accepted when in_valid && in_ready at clk edge.
- in_word  input  WORD_W  word payload.
- in_is_key  input  1  1 = word belongs to a key group, 0 = data group.
- key_clr  input  1  single-cycle pulse: erase key, discard partial group.
- blk_valid  output  1  blk_data/blk_key hold a complete block.
- blk_ready  input  1  downstream consumes block at clk edge when blk_valid && blk_ready.
- blk_data  output  BLK_W  assembled data block (to cipher data_in).
- blk_key  output  BLK_W  key snapshot for this block (to cipher key).
- key_valid  output  1  a full key has been loaded since reset/clear.
- err_mix  output  1  one-cycle pulse: group type changed mid-group.
- err_nokey  output  1  one-cycle pulse: data block completed with no valid key.

## Operation
- Shared shift register (BLK_W), 2-bit word counter cnt, group-type register grp_key.
- Packing is big-endian: word 0 -> bits [127:96], word 3 -> bits [31:0].
- Accepted word with cnt==0: latch grp_key = in_is_key, store word, cnt=1.
- Accepted word with cnt!=0 and in_is_key==grp_key: store word, cnt++ (3 wraps to 0 on completion).
- Accepted word with cnt!=0 and in_is_key!=grp_key: discard the partial group, err_mix=1 for one cycle. The word restarts a new group as word 0, cnt=1, grp_key=in_is_key.
- Key group completes (4th word): key_reg <= assembled value, key_valid <= 1. A key group never touches the output register.
- Data group completes with key_valid=1: blk_data <= assembled value, blk_key <= key_reg, blk_valid <= 1.
- Data group completes with key_valid=0: block dropped, err_nokey=1 for one cycle, blk_valid unchanged.
- blk_valid clears on the blk_ready handshake. blk_data and blk_key retain their last values.
- in_ready = rst && !blk_valid. Input is stalled entirely while a block is pending, so a key load cannot race a pending block.
- key_clr: key_reg <= 0, key_valid <= 0, cnt <= 0. Any input word in the same cycle is dropped, even if the handshake fires; key_clr wins. A pending blk_valid block is kept and still carries its snapshot key.
- Reset (rst==0 at edge): cnt=0, grp_key=0, shift register=0, key_reg=0, key_valid=0, blk_valid=0, blk_data=0, blk_key=0, err_mix=0, err_nokey=0. in_ready=0 while rst is low.

## Timing
- Data latency: if the 4th data word is accepted at edge N, blk_valid is high from edge N to the downstream handshake.
- Key latency: if the 4th key word is accepted at edge N, key_valid=1 after N. A data group completing at edge N+k (k≥1) uses the new key.
- The 4-word data group completing at the handshake edge itself is impossible because in_ready=0 while blk_valid=1. After the consuming edge, in_ready=1 in the next cycle.
- Throughput with blk_ready tied high: one block per 5 cycles (4 words plus 1 stall cycle).
- err_mix and err_nokey are registered pulses, asserted for exactly one cycle after the triggering edge.
- Reset mid-group: partial group lost, key lost, no error pulse.

## Structure
- Shared package cipher_pkg: WORD_W, BLK_W, WORDS_PER_BLK=4, and cnt width. The cipher stage imports the same BLK_W.
- No sub-module. A single shift register is shared by key and data groups, since only one group is in flight.

## Test plan
- Reset, then key words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, then data words 0xAAAAAAAA ×4, blk_ready=1 -> key_valid=1; blk_valid=1 with blk_data=0xAAAA…AA and blk_key=0x000102030405060708090A0B0C0D0E0F; no error pulses.
- Data group of 4 words before any key -> err_nokey pulses one cycle, blk_valid stays 0, in_ready stays 1.
- Key loaded, blk_ready=0, data block completes, then in_valid held high -> in_ready=0 until blk_ready=1. The block is consumed once, and the next word is accepted in the following cycle.
- Two data words, then a key word (in_is_key=1), then 3 more key words -> err_mix pulses once, and key_reg equals the 4 key words only.
- key_clr asserted in the same cycle as a handshaked 3rd data word -> word dropped, cnt=0, key_valid=0. A subsequent full data group triggers err_nokey.
- rst driven low after 2 key words over an existing valid key -> all outputs return to 0. A fresh key plus data sequence then behaves as in the first scenario.
